// File: rtl/bus_uart_packet_tx.sv
// bus_uart_packet_tx: serialises the bridge's packed transaction word as a
// fixed-length burst of UART 8N1 bytes (most significant byte first, LSB
// first within a byte). A one-entry pending buffer holds a word that arrives
// mid-packet. A word arriving while both the shifter and the pending buffer
// are full is dropped and flagged on overflow.
module bus_uart_packet_tx #(
    parameter int PKT_WIDTH    = 25,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [PKT_WIDTH-1:0] pkt_in,
    input  logic                 pkt_valid,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int NUM_BYTES = (PKT_WIDTH + 7) / 8;
    localparam int PAD_WIDTH = NUM_BYTES * 8;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int BAUD_W    = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [BYTE_W-1:0]    byte_idx, byte_idx_n;
    logic [PAD_WIDTH-1:0] shifter, shifter_n;
    logic [PKT_WIDTH-1:0] pending, pending_n;
    logic                 pending_valid, pending_valid_n;
    logic                 valid_q;
    logic                 done_arm, done_arm_n;
    logic                 overflow_n;
    logic                 tx_n;
    logic                 busy_n;

    logic                 arrival;
    logic                 baud_end;
    logic                 pkt_end;
    logic [PAD_WIDTH-1:0] pkt_in_pad;
    logic [PAD_WIDTH-1:0] pending_pad;
    logic [7:0]           cur_byte;

    // A new word is a rising edge of the strobe, so a held strobe counts once.
    assign arrival  = pkt_valid & ~valid_q;
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign pkt_end  = (state == STOP) && baud_end && (byte_idx == BYTE_LAST);
    // The byte on the wire is always the top byte; the shifter moves up a byte at a time.
    assign cur_byte = shifter[PAD_WIDTH-1 -: 8];

    // Zero-extend the incoming and pending words to a whole number of bytes.
    always_comb begin
        pkt_in_pad                   = '0;
        pkt_in_pad[PKT_WIDTH-1:0]    = pkt_in;
        pending_pad                  = '0;
        pending_pad[PKT_WIDTH-1:0]   = pending;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
        end
    end

    // Next-state, counter, buffer and output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n         = state;
        baud_cnt_n      = baud_cnt;
        bit_idx_n       = bit_idx;
        byte_idx_n      = byte_idx;
        shifter_n       = shifter;
        pending_n       = pending;
        pending_valid_n = pending_valid;
        done_arm_n      = 1'b0;
        overflow_n      = 1'b0;
        tx_n            = 1'b1;
        busy_n          = (state != IDLE) | pending_valid;

        if (state != IDLE) begin
            baud_cnt_n = baud_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (arrival) begin
                    shifter_n  = pkt_in_pad;
                    byte_idx_n = '0;
                    bit_idx_n  = '0;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_end) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                tx_n = cur_byte[bit_idx];
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (byte_idx != BYTE_LAST) begin
                        byte_idx_n = byte_idx + 1'b1;
                        shifter_n  = shifter << 8;
                        state_n    = START;
                    end else begin
                        done_arm_n = 1'b1;
                        byte_idx_n = '0;
                        state_n    = START;
                        if (pending_valid) begin
                            shifter_n       = pending_pad;
                            pending_valid_n = 1'b0;
                        end else if (arrival) begin
                            // Word lands exactly as the packet ends: send it with no idle bit.
                            shifter_n = pkt_in_pad;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // An arrival during a packet goes to the pending slot; the slot counts as
        // free in the cycle its old contents are promoted to the shifter.
        if (arrival && (state != IDLE) && !(pkt_end && !pending_valid)) begin
            if (!pending_valid || pkt_end) begin
                pending_n       = pkt_in;
                pending_valid_n = 1'b1;
            end else begin
                overflow_n = 1'b1;
            end
        end
    end

    // Datapath and registered outputs; the line lags the state register by one clock,
    // and done is delayed once more so it marks the end of the last stop bit on the line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_cnt      <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            shifter       <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            valid_q       <= 1'b0;
            done_arm      <= 1'b0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            baud_cnt      <= baud_cnt_n;
            bit_idx       <= bit_idx_n;
            byte_idx      <= byte_idx_n;
            shifter       <= shifter_n;
            pending       <= pending_n;
            pending_valid <= pending_valid_n;
            valid_q       <= pkt_valid;
            done_arm      <= done_arm_n;
            tx            <= tx_n;
            busy          <= busy_n;
            done          <= done_arm;
            overflow      <= overflow_n;
        end
    end

endmodule

// File: tb/tb_bus_uart_packet_tx.sv
// Self-checking bench for bus_uart_packet_tx with CLKS_PER_BIT=4.
// Outputs are logged each falling edge; expected waveforms come from a
// packet-level model (start edge of each accepted packet plus its data).
module tb_bus_uart_packet_tx;

    localparam int PW      = 25;
    localparam int CPB     = 4;
    localparam int NB      = 4;
    localparam int PKT_CYC = NB * 10 * CPB;
    localparam int MAXC    = 40000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [PW-1:0] pkt_in = '0;
    logic          pkt_valid = 1'b0;
    logic          tx, busy, done, overflow;

    bus_uart_packet_tx #(.PKT_WIDTH(PW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rstn(rstn), .pkt_in(pkt_in), .pkt_valid(pkt_valid),
        .tx(tx), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tx_log [MAXC];
    logic done_log [MAXC];
    logic ovf_log [MAXC];
    logic busy_log [MAXC];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            tx_log[cyc]   = tx;
            done_log[cyc] = done;
            ovf_log[cyc]  = overflow;
            busy_log[cyc] = busy;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    int            pk_start[$];
    logic [PW-1:0] pk_data[$];
    int            ovf_edge[$];
    int            cur_end = 0;
    bit            m_pend = 0;
    logic [PW-1:0] m_pend_d = '0;

    function automatic void model_clear();
        pk_start.delete(); pk_data.delete(); ovf_edge.delete();
        cur_end = 0; m_pend = 0;
    endfunction

    // Arrival sampled at clock edge c: idle transmitter starts at c; otherwise
    // the word waits in pending, which frees up when the running packet ends.
    function automatic void model_arrival(input int c, input logic [PW-1:0] d);
        if (m_pend && cur_end <= c) begin
            pk_start.push_back(cur_end); pk_data.push_back(m_pend_d);
            cur_end += PKT_CYC; m_pend = 0;
        end
        if (cur_end <= c) begin
            pk_start.push_back(c); pk_data.push_back(d);
            cur_end = c + PKT_CYC;
        end else if (!m_pend) begin
            m_pend = 1; m_pend_d = d;
        end else begin
            ovf_edge.push_back(c);
        end
    endfunction

    function automatic void model_flush();
        if (m_pend) begin
            pk_start.push_back(cur_end); pk_data.push_back(m_pend_d);
            cur_end += PKT_CYC; m_pend = 0;
        end
    endfunction

    // Line value logged after edge e: packet started at s occupies edges s+1..s+PKT_CYC.
    function automatic logic exp_tx(input int e);
        logic r = 1'b1;
        for (int i = 0; i < pk_start.size(); i++) begin
            if (e >= pk_start[i] + 1 && e <= pk_start[i] + PKT_CYC) begin
                int off  = e - pk_start[i] - 1;
                int bi   = off / (10 * CPB);
                int slot = (off % (10 * CPB)) / CPB;
                logic [31:0] w   = 32'(pk_data[i]);
                logic [7:0]  byt = 8'(w >> (8 * (NB - 1 - bi)));
                if (slot == 0)      r = 1'b0;
                else if (slot == 9) r = 1'b1;
                else                r = byt[slot-1];
            end
        end
        return r;
    endfunction

    function automatic logic exp_done(input int e);
        logic r = 1'b0;
        for (int i = 0; i < pk_start.size(); i++)
            if (e == pk_start[i] + PKT_CYC + 1) r = 1'b1;
        return r;
    endfunction

    function automatic logic exp_ovf(input int e);
        logic r = 1'b0;
        for (int i = 0; i < ovf_edge.size(); i++)
            if (e == ovf_edge[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic exp_busy(input int e);
        logic r = 1'b0;
        for (int i = 0; i < pk_start.size(); i++)
            if (e >= pk_start[i] + 1 && e <= pk_start[i] + PKT_CYC) r = 1'b1;
        return r;
    endfunction

    // Compare the logged waveforms over edges from..to against the model.
    task automatic check_window(input string name, input int from, input int to);
        int    miss [4];
        int    first [4];
        logic  got [4];
        logic  want [4];
        string sig [4] = '{"tx", "done", "overflow", "busy"};
        model_flush();
        for (int k = 0; k < 4; k++) begin miss[k] = 0; first[k] = -1; got[k] = 1'b0; want[k] = 1'b0; end
        for (int e = from; e <= to; e++) begin
            logic a [4];
            logic x [4];
            a[0] = tx_log[e];   x[0] = exp_tx(e);
            a[1] = done_log[e]; x[1] = exp_done(e);
            a[2] = ovf_log[e];  x[2] = exp_ovf(e);
            a[3] = busy_log[e]; x[3] = exp_busy(e);
            for (int k = 0; k < 4; k++) begin
                if (a[k] !== x[k]) begin
                    if (miss[k] == 0) begin first[k] = e; got[k] = a[k]; want[k] = x[k]; end
                    miss[k]++;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (miss[k] != 0) begin
                errors++;
                $display("FAIL %s.%s: %0d cycle(s) differ, first at edge %0d: got %b, expected %b",
                         name, sig[k], miss[k], first[k], got[k], want[k]);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; the arrival is sampled on the next rising edge.
    task automatic strobe(input logic [PW-1:0] d, input int hold);
        pkt_in = d; pkt_valid = 1'b1;
        model_arrival(cyc + 1, d);
        repeat (hold) @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic strobe_at(input int edge_no, input logic [PW-1:0] d);
        while (cyc + 1 < edge_no) @(negedge clk);
        strobe(d, 1);
    endtask

    function automatic void decode(input int t0, output logic [31:0] bytes, output int ferr);
        logic [7:0] v;
        bytes = '0; ferr = 0; v = '0;
        for (int k = 0; k < NB; k++) begin
            int b = t0 + k * 10 * CPB;
            if (tx_log[b + CPB/2] !== 1'b0) ferr++;
            for (int j = 0; j < 8; j++) v[j] = tx_log[b + (1 + j) * CPB + CPB/2];
            if (tx_log[b + 9 * CPB + CPB/2] !== 1'b1) ferr++;
            bytes = {bytes[23:0], v};
        end
    endfunction

    typedef struct {
        logic [PW-1:0] pkt;
        int            hold;
        logic [31:0]   bytes;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    initial begin
        int from, a, t0, ferr;
        logic [31:0] got_bytes;

        vecs[0] = '{pkt: 25'h1_1234_AB, hold: 1,  bytes: 32'h01_12_34_AB};
        vecs[1] = '{pkt: 25'h0_0000_5A, hold: 20, bytes: 32'h00_00_00_5A};
        vecs[2] = '{pkt: 25'h0_BEEF_01, hold: 3,  bytes: 32'h00_BE_EF_01};
        vecs[3] = '{pkt: 25'h1FF_FFFF,  hold: 1,  bytes: 32'h01_FF_FF_FF};
        vecs[4] = '{pkt: 25'h0,         hold: 2,  bytes: 32'h00_00_00_00};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_overflow", overflow, 0);
        rstn = 1'b1;
        model_clear(); from = cyc + 1;
        repeat (100) @(negedge clk);
        check_window("idle_100", from, cyc - 2);

        // Table-driven single packets.
        for (int i = 0; i < 5; i++) begin
            model_clear(); from = cyc + 1;
            a = cyc + 1;
            strobe(vecs[i].pkt, vecs[i].hold);
            repeat (PKT_CYC + 20) @(negedge clk);
            t0 = -1;
            for (int e = a; e <= a + 20; e++)
                if (t0 < 0 && tx_log[e] === 1'b0) t0 = e;
            check($sformatf("vec%0d_latency", i), t0, a + 1);
            if (t0 >= 0) begin
                decode(t0, got_bytes, ferr);
                check($sformatf("vec%0d_bytes", i), got_bytes, vecs[i].bytes);
                check($sformatf("vec%0d_framing", i), ferr, 0);
                check($sformatf("vec%0d_done", i), done_log[t0 + PKT_CYC], 1);
                check($sformatf("vec%0d_busy_drop", i), busy_log[t0 + PKT_CYC], 0);
            end
            check_window($sformatf("vec%0d", i), from, cyc - 2);
        end

        // Back-to-back: second word strobed mid-way through the first.
        model_clear(); from = cyc + 1;
        strobe(25'h1_1234_AB, 1);
        repeat (70) @(negedge clk);
        strobe(25'h0_BEEF_01, 1);
        repeat (2 * PKT_CYC + 20) @(negedge clk);
        check_window("back_to_back", from, cyc - 2);

        // Overflow: three strobes during the first packet.
        model_clear(); from = cyc + 1;
        strobe(25'h0_1111_11, 1);
        repeat (30) @(negedge clk);
        strobe(25'h0_2222_22, 1);
        repeat (30) @(negedge clk);
        strobe(25'h0_3333_33, 1);
        repeat (2 * PKT_CYC + 20) @(negedge clk);
        check_window("overflow", from, cyc - 2);

        // Arrival in the same cycle pending is promoted.
        model_clear(); from = cyc + 1; a = cyc + 2;
        strobe_at(a, 25'h0_A0A0_A0);
        strobe_at(a + 20, 25'h1_5555_AA);
        strobe_at(a + PKT_CYC, 25'h0_C3C3_3C);
        repeat (3 * PKT_CYC + 20) @(negedge clk);
        check_window("promote_and_arrive", from, cyc - 2);

        // Arrival in the same cycle the packet ends with pending empty.
        model_clear(); from = cyc + 1; a = cyc + 2;
        strobe_at(a, 25'h0_0F0F_F0);
        strobe_at(a + PKT_CYC, 25'h1_8001_7E);
        repeat (2 * PKT_CYC + 20) @(negedge clk);
        check_window("direct_reload", from, cyc - 2);

        // Randomised traffic.
        model_clear(); from = cyc + 1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(1, 120)) @(negedge clk);
            strobe(PW'($urandom()), int'($urandom_range(1, 4)));
        end
        repeat (3 * PKT_CYC + 20) @(negedge clk);
        check_window("random", from, cyc - 2);

        // Reset during a data bit of the third byte, with a word pending.
        model_clear(); a = cyc + 2;
        strobe_at(a, 25'h1_1234_AB);
        strobe_at(a + 30, 25'h0_7777_77);
        while (cyc < a + 86) @(negedge clk);
        check("pre_reset_tx", tx, 0);
        rstn = 1'b0;
        #1;
        check("midframe_reset_tx", tx, 1);
        check("midframe_reset_busy", busy, 0);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        model_clear(); from = cyc + 1;
        repeat (2 * PKT_CYC) @(negedge clk);
        check_window("after_reset_quiet", from, cyc - 2);
        model_clear(); from = cyc + 1;
        strobe(25'h1_1234_AB, 1);
        repeat (PKT_CYC + 20) @(negedge clk);
        check_window("after_reset_packet", from, cyc - 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
